// File: rtl/sum_accumulator_pkg.sv
// Shared definitions for the frame accumulator: state encoding, default
// geometry and the counter-width helper.
package sum_accumulator_pkg;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } state_t;

  localparam int DEF_IN_WIDTH  = 2;
  localparam int DEF_ACC_WIDTH = 8;
  localparam int DEF_COUNT     = 4;

  // Beat counter width; a one-beat frame still needs a 1-bit register.
  function automatic int cnt_width(input int count);
    return (count <= 1) ? 1 : $clog2(count);
  endfunction

endpackage

// File: rtl/sat_add.sv
// Unsigned saturating adder: clamps to all ones when the true sum does not
// fit in ACC_WIDTH bits and flags that it did so.
module sat_add #(
  parameter int ACC_WIDTH = 8
) (
  input  logic [ACC_WIDTH-1:0] acc,
  input  logic [ACC_WIDTH-1:0] operand,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 saturate
);

  logic [ACC_WIDTH:0] full_sum;

  // One extra bit catches the carry that signals overflow.
  always_comb begin
    full_sum = {1'b0, acc} + {1'b0, operand};
    saturate = full_sum[ACC_WIDTH];
    result   = saturate ? '1 : full_sum[ACC_WIDTH-1:0];
  end

endmodule

// File: rtl/sum_accumulator.sv
// Frame accumulator: sums COUNT accepted input beats with saturation and
// holds each frame total on a valid/ready output until the consumer takes it.
module sum_accumulator
  import sum_accumulator_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int COUNT     = DEF_COUNT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_sum,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_total,
  output logic                 out_overflow
);

  localparam int CNT_W = cnt_width(COUNT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

  state_t               state, state_next;
  logic [ACC_WIDTH-1:0] acc, acc_next;
  logic [CNT_W-1:0]     cnt, cnt_next;
  logic                 ovf, ovf_next;

  logic [ACC_WIDTH-1:0] sum_sat;
  logic                 sat_flag;

  sat_add #(
    .ACC_WIDTH (ACC_WIDTH)
  ) u_sat_add (
    .acc      (acc),
    .operand  (ACC_WIDTH'(in_sum)),
    .result   (sum_sat),
    .saturate (sat_flag)
  );

  // Outputs depend only on registered state and clear, never on in_valid
  // or out_ready.
  always_comb begin
    in_ready     = (state == ST_ACCUM) && !clear;
    out_valid    = (state == ST_DONE);
    out_total    = acc;
    out_overflow = ovf;
  end

  // Next-state logic: clear aborts the frame, otherwise accumulate beats
  // or wait for the output handshake.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_next = state;
    acc_next   = acc;
    cnt_next   = cnt;
    ovf_next   = ovf;

    if (clear) begin
      state_next = ST_ACCUM;
      acc_next   = '0;
      cnt_next   = '0;
      ovf_next   = 1'b0;
    end else begin
      unique case (state)
        ST_ACCUM: begin
          if (in_valid) begin
            acc_next = sum_sat;
            ovf_next = ovf | sat_flag;
            if (cnt == LAST_CNT) begin
              cnt_next   = '0;
              state_next = ST_DONE;
            end else begin
              cnt_next = cnt + 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            acc_next   = '0;
            ovf_next   = 1'b0;
            state_next = ST_ACCUM;
          end
        end
        default: state_next = ST_ACCUM;
      endcase
    end
  end

  // State register with asynchronous clear of everything; a pending total
  // is lost on reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_ACCUM;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples the values
      // from before this edge.
      state <= state_next;
      acc   <= acc_next;
      cnt   <= cnt_next;
      ovf   <= ovf_next;
    end
  end

endmodule
